// File: rtl/rx_port_pkg.sv
// Shared types and constants for the rx_port scatter-gather element reader.
package rx_port_pkg;

  localparam int WORDS_PER_ELEM = 4;
  localparam int WORD_W         = 32;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] len;
  } sg_elem_t;

  // Word 3 of an element is reserved, so only the first three words matter.
  function automatic sg_elem_t packElem(input logic [WORD_W-1:0] addrLo,
                                        input logic [WORD_W-1:0] addrHi,
                                        input logic [WORD_W-1:0] len);
    sg_elem_t e;
    e.addr = {addrHi, addrLo};
    e.len  = len;
    return e;
  endfunction

endpackage

// File: rtl/sg_elem_fifo.sv
// Show-ahead FIFO of SG elements; the head is presented combinationally and
// reads as zero while the queue is empty. A push on a full queue is accepted
// only when a pop happens in the same cycle.
module sg_elem_fifo
  import rx_port_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     CLK,
  input  logic     rRst,
  input  logic     i_flush,
  input  logic     i_push,
  input  sg_elem_t i_pushData,
  input  logic     i_pop,
  output sg_elem_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sg_elem_t       r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [CW-1:0]  r_count;
  logic           w_doPush;
  logic           w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty && !i_flush;
  assign w_doPush = i_push && (!o_full || w_doPop) && !i_flush;
  assign o_head   = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge CLK or posedge rRst) begin
    if (rRst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; o_head masks it while the queue is empty.
  always_ff @(posedge CLK) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/rx_port.sv
// Receive-side SG element reader: packs a 32-bit word stream into 4-word
// elements and queues them. Optional RX_PORT_ELEM_COUNT_EN adds SG_ELEM_COUNT.
module rx_port
  import rx_port_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_SG_FIFO_DEPTH   = 16,
  parameter int C_DATA_WORD_WIDTH = $clog2(C_DATA_WIDTH/32 + 1)
) (
  input  logic                         CLK,
  input  logic                         rRst,
  input  logic                         SG_RST,
  input  logic [C_DATA_WIDTH-1:0]      SG_RX_DATA,
  input  logic [C_DATA_WORD_WIDTH-1:0] SG_RX_DATA_EN,
  input  logic                         SG_RX_DONE,
  input  logic                         SG_RX_ERR,
  output logic [63:0]                  SG_ELEM_ADDR,
  output logic [31:0]                  SG_ELEM_LEN,
  output logic                         SG_ELEM_RDY,
  input  logic                         SG_ELEM_REN,
  output logic                         SG_LIST_ERR,
`ifdef RX_PORT_ELEM_COUNT_EN
  output logic [15:0]                  SG_ELEM_COUNT,
`endif
  output logic                         SG_OVERFLOW
);

  localparam int MAXW = C_DATA_WIDTH / WORD_W;

  logic [WORD_W-1:0] w_lane [MAXW];
  logic [WORD_W-1:0] r_stage [3];
  logic [1:0]        r_stageCnt;
  logic [WORD_W-1:0] w_lo [3];
  logic [WORD_W-1:0] w_hi [3];
  logic [2:0]        w_en;
  logic [2:0]        w_pos;
  logic [2:0]        w_total;
  logic [1:0]        w_nextCnt;
  logic              w_complete;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              r_listErr;
  logic              r_overflow;
  sg_elem_t          w_elem;
  sg_elem_t          w_head;

  for (genvar k = 0; k < MAXW; k++) begin : g_lane
    assign w_lane[k] = SG_RX_DATA[k*WORD_W +: WORD_W];
  end

  always_comb begin
    w_en = 3'(SG_RX_DATA_EN);
    if (SG_RX_DATA_EN > C_DATA_WORD_WIDTH'(MAXW)) w_en = 3'(MAXW);
  end

  // Concatenate staged words and incoming lanes into positions 0..6; position 3
  // is the reserved word and is dropped, 0..2 feed the element or the staging,
  // 4..6 are the carry-over when an element completes.
  always_comb begin
    w_pos = '0;
    for (int j = 0; j < 3; j++) begin
      w_lo[j] = (2'(j) < r_stageCnt) ? r_stage[j] : '0;
      w_hi[j] = '0;
    end
    for (int k = 0; k < MAXW; k++) begin
      if (3'(k) < w_en) begin
        w_pos = {1'b0, r_stageCnt} + 3'(k);
        if (w_pos < 3'd3) w_lo[w_pos[1:0]] = w_lane[k];
        else if (w_pos > 3'd3) w_hi[2'(w_pos - 3'd4)] = w_lane[k];
      end
    end
    w_total    = {1'b0, r_stageCnt} + w_en;
    w_complete = (w_total >= 3'(WORDS_PER_ELEM));
    w_nextCnt  = w_complete ? 2'(w_total - 3'(WORDS_PER_ELEM)) : 2'(w_total);
    w_elem     = packElem(w_lo[0], w_lo[1], w_lo[2]);
  end

  assign w_push = w_complete && !SG_RX_ERR && !SG_RST;

  always_ff @(posedge CLK or posedge rRst) begin
    if (rRst) begin
      r_stageCnt <= '0;
      r_listErr  <= 1'b0;
      r_overflow <= 1'b0;
      for (int j = 0; j < 3; j++) r_stage[j] <= '0;
    end else if (SG_RST) begin
      r_stageCnt <= '0;
      r_listErr  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (SG_RX_ERR) begin
      r_stageCnt <= '0;
      r_listErr  <= 1'b1;
    end else begin
      for (int j = 0; j < 3; j++) r_stage[j] <= w_complete ? w_hi[j] : w_lo[j];
      if (SG_RX_DONE) begin
        r_stageCnt <= '0;
        if (w_nextCnt != 2'd0) r_listErr <= 1'b1;
      end else begin
        r_stageCnt <= w_nextCnt;
      end
      // A full queue is never empty, so REN here is always an accepted pop.
      if (w_push && w_full && !SG_ELEM_REN) r_overflow <= 1'b1;
    end
  end

  sg_elem_fifo #(
    .DEPTH(C_SG_FIFO_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .rRst       (rRst),
    .i_flush    (SG_RST),
    .i_push     (w_push),
    .i_pushData (w_elem),
    .i_pop      (SG_ELEM_REN),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign SG_ELEM_ADDR = w_head.addr;
  assign SG_ELEM_LEN  = w_head.len;
  assign SG_ELEM_RDY  = !w_empty;
  assign SG_LIST_ERR  = r_listErr;
  assign SG_OVERFLOW  = r_overflow;

`ifdef RX_PORT_ELEM_COUNT_EN
  logic [15:0] r_elemCount;

  always_ff @(posedge CLK or posedge rRst) begin
    if (rRst)                            r_elemCount <= '0;
    else if (SG_RST)                     r_elemCount <= '0;
    else if (SG_ELEM_REN && !w_empty)    r_elemCount <= r_elemCount + 16'd1;
  end

  assign SG_ELEM_COUNT = r_elemCount;
`endif

endmodule

// File: tb/tb_rx_port.sv
// Randomized self-checking bench for rx_port against a word-queue reference model.
module tb_rx_port;
  import rx_port_pkg::*;

  localparam int DEPTH = 4;

  logic         CLK;
  logic         rRst;
  logic         SG_RST;
  logic [127:0] SG_RX_DATA;
  logic [2:0]   SG_RX_DATA_EN;
  logic         SG_RX_DONE;
  logic         SG_RX_ERR;
  logic [63:0]  SG_ELEM_ADDR;
  logic [31:0]  SG_ELEM_LEN;
  logic         SG_ELEM_RDY;
  logic         SG_ELEM_REN;
  logic         SG_LIST_ERR;
  logic         SG_OVERFLOW;

  int tests;
  int failures;

  logic [31:0] mStage[$];
  sg_elem_t    mQ[$];
  bit          mErr;
  bit          mOvf;

  rx_port #(
    .C_DATA_WIDTH    (128),
    .C_SG_FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK           (CLK),
    .rRst          (rRst),
    .SG_RST        (SG_RST),
    .SG_RX_DATA    (SG_RX_DATA),
    .SG_RX_DATA_EN (SG_RX_DATA_EN),
    .SG_RX_DONE    (SG_RX_DONE),
    .SG_RX_ERR     (SG_RX_ERR),
    .SG_ELEM_ADDR  (SG_ELEM_ADDR),
    .SG_ELEM_LEN   (SG_ELEM_LEN),
    .SG_ELEM_RDY   (SG_ELEM_RDY),
    .SG_ELEM_REN   (SG_ELEM_REN),
    .SG_LIST_ERR   (SG_LIST_ERR),
    .SG_OVERFLOW   (SG_OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mkData(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic void modelClear();
    mStage.delete();
    mQ.delete();
    mErr = 0;
    mOvf = 0;
  endfunction

  // One clock edge of the behavioural model: words append to a staging queue,
  // any four leading words become an element, then pop/push on the element queue.
  function automatic void modelEdge(input logic [2:0] en, input logic [127:0] data,
                                    input bit done, input bit err, input bit ren, input bit sgrst);
    bit       doPop;
    bit       wasFull;
    bit       doPush;
    sg_elem_t e;
    int       cnt;
    if (sgrst) begin
      modelClear();
      return;
    end
    doPop   = ren && (mQ.size() > 0);
    wasFull = (mQ.size() == DEPTH);
    doPush  = 0;
    e       = '0;
    if (err) begin
      mStage.delete();
      mErr = 1;
    end else begin
      cnt = (en > 4) ? 4 : int'(en);
      for (int k = 0; k < cnt; k++) mStage.push_back(data[k*32 +: 32]);
      if (mStage.size() >= 4) begin
        e.addr = {mStage[1], mStage[0]};
        e.len  = mStage[2];
        for (int k = 0; k < 4; k++) void'(mStage.pop_front());
        doPush = 1;
      end
      if (done) begin
        if (mStage.size() != 0) mErr = 1;
        mStage.delete();
      end
    end
    if (doPop) void'(mQ.pop_front());
    if (doPush) begin
      if (wasFull && !doPop) mOvf = 1;
      else mQ.push_back(e);
    end
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, "_rdy"}, 64'(SG_ELEM_RDY), 64'(mQ.size() != 0));
    if (mQ.size() != 0) begin
      checkOutput({tag, "_addr"}, SG_ELEM_ADDR, mQ[0].addr);
      checkOutput({tag, "_len"}, 64'(SG_ELEM_LEN), 64'(mQ[0].len));
    end
    checkOutput({tag, "_err"}, 64'(SG_LIST_ERR), 64'(mErr));
    checkOutput({tag, "_ovf"}, 64'(SG_OVERFLOW), 64'(mOvf));
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] en, input logic [127:0] data,
                               input bit done, input bit err, input bit ren, input bit sgrst);
    SG_RX_DATA_EN = en;
    SG_RX_DATA    = data;
    SG_RX_DONE    = done;
    SG_RX_ERR     = err;
    SG_ELEM_REN   = ren;
    SG_RST        = sgrst;
    @(posedge CLK);
    modelEdge(en, data, done, err, ren, sgrst);
    #1;
    compareAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 3'd0, '0, 0, 0, 0, 0);
  endtask

  task automatic pushElem(input string tag, input logic [63:0] addr, input logic [31:0] len, input bit ren);
    applyStimulus(tag, 3'd4, mkData(addr[31:0], addr[63:32], len, 32'hFFFF_FFFF), 0, 0, ren, 0);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    modelClear();
    rRst          = 1'b1;
    SG_RST        = 1'b0;
    SG_RX_DATA    = '0;
    SG_RX_DATA_EN = '0;
    SG_RX_DONE    = 1'b0;
    SG_RX_ERR     = 1'b0;
    SG_ELEM_REN   = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    checkOutput("reset_rdy", 64'(SG_ELEM_RDY), 64'd0);
    checkOutput("reset_addr", SG_ELEM_ADDR, 64'd0);
    checkOutput("reset_len", 64'(SG_ELEM_LEN), 64'd0);
    checkOutput("reset_err", 64'(SG_LIST_ERR), 64'd0);
    checkOutput("reset_ovf", 64'(SG_OVERFLOW), 64'd0);
    rRst = 1'b0;

    // Full-width element
    applyStimulus("full", 3'd4, mkData(32'h1000_0000, 32'h0000_0001, 32'h0000_0040, 32'hDEAD_BEEF), 0, 0, 0, 0);
    checkOutput("full_rdy_c", 64'(SG_ELEM_RDY), 64'd1);
    checkOutput("full_addr_c", SG_ELEM_ADDR, 64'h0000_0001_1000_0000);
    checkOutput("full_len_c", 64'(SG_ELEM_LEN), 64'h40);
    applyStimulus("full_pop", 3'd0, '0, 0, 0, 1, 0);
    checkOutput("full_pop_rdy_c", 64'(SG_ELEM_RDY), 64'd0);

    // Split and carry: A = (0x100, 8), B = (0x200, 16)
    applyStimulus("split1", 3'd3, mkData(32'h100, 32'h0, 32'd8, 32'h0), 0, 0, 0, 0);
    checkOutput("split1_rdy_c", 64'(SG_ELEM_RDY), 64'd0);
    applyStimulus("split2", 3'd4, mkData(32'h0, 32'h200, 32'h0, 32'd16), 0, 0, 0, 0);
    checkOutput("split2_addr_c", SG_ELEM_ADDR, 64'h100);
    applyStimulus("split3", 3'd1, mkData(32'h0, 32'h0, 32'h0, 32'h0), 0, 0, 0, 0);
    applyStimulus("split_popA", 3'd0, '0, 0, 0, 1, 0);
    checkOutput("split_B_addr_c", SG_ELEM_ADDR, 64'h200);
    checkOutput("split_B_len_c", 64'(SG_ELEM_LEN), 64'd16);
    applyStimulus("split_popB", 3'd0, '0, 0, 0, 1, 0);

    // Done with leftover words
    applyStimulus("done1", 3'd2, mkData(32'h11, 32'h22, 32'h0, 32'h0), 0, 0, 0, 0);
    applyStimulus("done2", 3'd0, '0, 1, 0, 0, 0);
    checkOutput("done_err_c", 64'(SG_LIST_ERR), 64'd1);
    checkOutput("done_rdy_c", 64'(SG_ELEM_RDY), 64'd0);
    applyStimulus("done_sgrst", 3'd0, '0, 0, 0, 0, 1);
    checkOutput("done_sgrst_err_c", 64'(SG_LIST_ERR), 64'd0);

    // Error input discards the cycle's data but keeps the queue
    pushElem("errin_push", 64'h0000_0003_0000_0300, 32'd24, 0);
    applyStimulus("errin_err", 3'd4, mkData(32'h999, 32'h0, 32'd5, 32'h0), 0, 1, 0, 0);
    checkOutput("errin_err_c", 64'(SG_LIST_ERR), 64'd1);
    checkOutput("errin_addr_c", SG_ELEM_ADDR, 64'h0000_0003_0000_0300);
    applyStimulus("errin_pop", 3'd0, '0, 0, 0, 1, 0);
    checkOutput("errin_empty_c", 64'(SG_ELEM_RDY), 64'd0);
    applyStimulus("errin_clr", 3'd0, '0, 0, 0, 0, 1);

    // Overflow: five pushes into a depth-4 queue
    for (int i = 1; i <= 5; i++) pushElem("ovf_push", 64'(i) << 12, 32'(i), 0);
    checkOutput("ovf_flag_c", 64'(SG_OVERFLOW), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("ovf_order_c", SG_ELEM_ADDR, 64'(i) << 12);
      applyStimulus("ovf_pop", 3'd0, '0, 0, 0, 1, 0);
    end
    checkOutput("ovf_drained_c", 64'(SG_ELEM_RDY), 64'd0);
    applyStimulus("ovf_clr", 3'd0, '0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) pushElem("full_push", 64'(i) << 8, 32'(i), 0);
    pushElem("full_pushpop", 64'h500, 32'd5, 1);
    checkOutput("pushpop_ovf_c", 64'(SG_OVERFLOW), 64'd0);
    checkOutput("pushpop_head_c", SG_ELEM_ADDR, 64'h200);

    // Asynchronous reset mid-stream
    applyStimulus("pre_rst", 3'd3, mkData(32'h7, 32'h8, 32'h9, 32'h0), 1, 0, 0, 0);
    #2;
    rRst = 1'b1;
    #1;
    checkOutput("async_rdy", 64'(SG_ELEM_RDY), 64'd0);
    checkOutput("async_addr", SG_ELEM_ADDR, 64'd0);
    checkOutput("async_len", 64'(SG_ELEM_LEN), 64'd0);
    checkOutput("async_err", 64'(SG_LIST_ERR), 64'd0);
    checkOutput("async_ovf", 64'(SG_OVERFLOW), 64'd0);
    modelClear();
    @(posedge CLK);
    #1;
    rRst = 1'b0;

    // Randomized traffic including clamped EN values
    for (int c = 0; c < 600; c++) begin
      logic [2:0]   en;
      logic [127:0] data;
      bit done, err, ren, sgrst;
      en    = 3'($urandom_range(0, 7));
      data  = {$urandom, $urandom, $urandom, $urandom};
      done  = ($urandom_range(0, 15) == 0);
      err   = ($urandom_range(0, 31) == 0);
      ren   = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 7);
      sgrst = ($urandom_range(0, 63) == 0);
      applyStimulus("rand", en, data, done, err, ren, sgrst);
    end
    idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
